hazard_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage pipelined CPU; sits beside the forwarding unit.

---
 rtl/hazard_controller_pkg.sv | 48 ++++
 rtl/hazard_controller_if.sv | 41 ++++
 rtl/hazard_controller_sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 110 +++++++++++
 tb/tb_hazard_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the hazard_controller pipeline sequencer:
// FSM state encoding and the bundled stage-register control word.
package hazard_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic mdu_req;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idexe_write;
    logic idexe_flush;
    logic exemem_bubble;
  } hz_ctrl_t;

  // Free-running pipeline: every stage loads, nothing cleared.
  localparam hz_ctrl_t CTRL_DEFAULT = '{
    mdu_req:       1'b0,
    pc_write:      1'b1,
    ifid_write:    1'b1,
    ifid_flush:    1'b0,
    idexe_write:   1'b1,
    idexe_flush:   1'b0,
    exemem_bubble: 1'b1 & 1'b0
  };

  // Front end frozen while the MDU owns the EX slot; EX/MEM fed NOPs.
  localparam hz_ctrl_t CTRL_FREEZE = '{
    mdu_req:       1'b0,
    pc_write:      1'b0,
    ifid_write:    1'b0,
    ifid_flush:    1'b0,
    idexe_write:   1'b0,
    idexe_flush:   1'b0,
    exemem_bubble: 1'b1
  };

  function automatic logic src_hit(input logic use_src, input logic eq);
    return use_src && eq;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] IFID_rs1;
  logic [REG_AW-1:0] IFID_rs2;
  logic              IFID_use_rs1;
  logic              IFID_use_rs2;
  logic [REG_AW-1:0] IDEXE_rd;
  logic              IDEXE_MemRead;
  logic              branch_taken;
  logic              mdu_start;
  logic              mdu_done;

  logic              mdu_req;
  logic              PC_Write;
  logic              IFID_Write;
  logic              IFID_Flush;
  logic              IDEXE_Write;
  logic              IDEXE_Flush;
  logic              EXEMEM_Bubble;
  logic              mdu_timeout_err;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
    output IDEXE_rd, IDEXE_MemRead, branch_taken, mdu_start, mdu_done,
    input  mdu_req, PC_Write, IFID_Write, IFID_Flush, IDEXE_Write, IDEXE_Flush,
    input  EXEMEM_Bubble, mdu_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
    input  IDEXE_rd, IDEXE_MemRead, branch_taken, mdu_start, mdu_done,
    output mdu_req, PC_Write, IFID_Write, IFID_Flush, IDEXE_Write, IDEXE_Flush,
    output EXEMEM_Bubble, mdu_timeout_err, stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr_n clears synchronously.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr_n,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and MDU freeze,
// with saturating stall/flush statistics and a sticky MDU timeout flag.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave hz
);

  localparam int               TMO_W    = $clog2(MDU_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

  hz_state_e        state_q;
  hz_state_e        state_d;
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  hz_ctrl_t         ctrl;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             tmo_hit;
  logic             flush_evt;

  assign rs1_hit  = src_hit(hz.IFID_use_rs1, hz.IDEXE_rd == hz.IFID_rs1);
  assign rs2_hit  = src_hit(hz.IFID_use_rs2, hz.IDEXE_rd == hz.IFID_rs2);
  assign load_use = hz.IDEXE_MemRead && (hz.IDEXE_rd != REG_AW'(REG_ZERO)) && (rs1_hit || rs2_hit);

  // A late done on the release cycle is a normal completion, not a timeout.
  assign tmo_hit  = (state_q == MDU_WAIT) && (tmo_q == TMO_LAST) && !hz.mdu_done;

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_d   = state_q;
    flush_evt = 1'b0;
    if (rst_n) begin
      if (state_q == RUN) begin
        if (hz.branch_taken) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idexe_flush = 1'b1;
          flush_evt        = 1'b1;
        end else if (hz.mdu_start) begin
          ctrl         = CTRL_FREEZE;
          ctrl.mdu_req = 1'b1;
          state_d      = MDU_WAIT;
        end else if (load_use) begin
          ctrl.pc_write    = 1'b0;
          ctrl.ifid_write  = 1'b0;
          ctrl.idexe_flush = 1'b1;
        end
      end else begin
        ctrl = CTRL_FREEZE;
        if (hz.mdu_done || tmo_hit) begin
          ctrl    = CTRL_DEFAULT;
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == MDU_WAIT) && (state_d == MDU_WAIT)) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .en    (!ctrl.pc_write),
    .clr_n (rst_n),
    .q     (hz.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .en    (flush_evt),
    .clr_n (rst_n),
    .q     (hz.flush_events)
  );

  assign hz.mdu_req         = ctrl.mdu_req;
  assign hz.PC_Write        = ctrl.pc_write;
  assign hz.IFID_Write      = ctrl.ifid_write;
  assign hz.IFID_Flush      = ctrl.ifid_flush;
  assign hz.IDEXE_Write     = ctrl.idexe_write;
  assign hz.IDEXE_Flush     = ctrl.idexe_flush;
  assign hz.EXEMEM_Bubble   = ctrl.exemem_bubble;
  assign hz.mdu_timeout_err = err_q;

  // A branch and an MDU op cannot both own the EX slot.
  a_branch_mdu_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == RUN) && hz.branch_taken && hz.mdu_start));

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, saturation runs and
// randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int CMAX = (1 << CW) - 1;

  // {mdu_req, PC_Write, IFID_Write, IFID_Flush, IDEXE_Write, IDEXE_Flush, EXEMEM_Bubble}
  localparam logic [6:0] DEF = 7'b0110100;
  localparam logic [6:0] BRF = 7'b0111110;
  localparam logic [6:0] LUS = 7'b0000110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] STA = 7'b1000001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_AW(AW), .CNT_W(CW)) hz();

  hazard_controller #(.REG_AW(AW), .CNT_W(CW), .MDU_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    string          name;
    logic           rst;
    logic [AW-1:0]  rs1, rs2, rd;
    logic           u1, u2, mr, br, ms, md;
    logic [6:0]     ctrl;
    int             stall;
    int             flush;
    logic           err;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;

  // Model: m_wait < 0 means the pipeline runs freely, otherwise it is the
  // number of cycles already spent waiting on the MDU.
  int   m_wait  = -1;
  int   m_stall = 0;
  int   m_flush = 0;
  logic m_err   = 1'b0;

  function automatic vec_t mk(input string n, input logic r, input int rs1, input int rs2, input int rd,
                              input logic u1, input logic u2, input logic mr, input logic br,
                              input logic ms, input logic md, input logic [6:0] c,
                              input int st, input int fl, input logic er);
    vec_t v;
    v.name = n;  v.rst = r;
    v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd);
    v.u1 = u1; v.u2 = u2; v.mr = mr; v.br = br; v.ms = ms; v.md = md;
    v.ctrl = c; v.stall = st; v.flush = fl; v.err = er;
    return v;
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_step(input vec_t v, output logic [6:0] exp);
    logic lu;
    lu  = v.mr && (v.rd != 0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    exp = DEF;
    if (!v.rst) begin
      m_wait = -1; m_stall = 0; m_flush = 0; m_err = 1'b0;
    end else begin
      if (m_wait < 0) begin
        if (v.br) begin
          exp = BRF; m_flush = sat_inc(m_flush);
        end else if (v.ms) begin
          exp = STA; m_wait = 0;
        end else if (lu) begin
          exp = LUS;
        end
      end else if (v.md) begin
        m_wait = -1;
      end else if (m_wait == TMO - 1) begin
        m_wait = -1; m_err = 1'b1;
      end else begin
        exp = FRZ; m_wait = m_wait + 1;
      end
      if (!exp[5]) m_stall = sat_inc(m_stall);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_model);
    logic [6:0] mexp;
    logic [6:0] got;
    @(negedge clk);
    rst_n            = v.rst;
    hz.IFID_rs1      = v.rs1;
    hz.IFID_rs2      = v.rs2;
    hz.IFID_use_rs1  = v.u1;
    hz.IFID_use_rs2  = v.u2;
    hz.IDEXE_rd      = v.rd;
    hz.IDEXE_MemRead = v.mr;
    hz.branch_taken  = v.br;
    hz.mdu_start     = v.ms;
    hz.mdu_done      = v.md;
    #1;
    got = {hz.mdu_req, hz.PC_Write, hz.IFID_Write, hz.IFID_Flush,
           hz.IDEXE_Write, hz.IDEXE_Flush, hz.EXEMEM_Bubble};
    model_step(v, mexp);
    check({v.name, " ctrl"}, 32'(got), 32'(use_model ? mexp : v.ctrl));
    @(posedge clk);
    #1;
    check({v.name, " stall_cycles"}, 32'(hz.stall_cycles), use_model ? m_stall : v.stall);
    check({v.name, " flush_events"}, 32'(hz.flush_events), use_model ? m_flush : v.flush);
    check({v.name, " mdu_timeout_err"}, 32'(hz.mdu_timeout_err), 32'(use_model ? m_err : v.err));
  endtask

  initial begin
    vec_t tbl[28];
    vec_t r;
    //               name              rst rs1 rs2 rd  u1 u2 mr br ms md  ctrl stall flush err
    tbl[0]  = mk("reset",           0, 0, 0, 0,  0, 0, 0, 0, 0, 0, DEF,  0, 0, 0);
    tbl[1]  = mk("idle",            1, 0, 0, 0,  0, 0, 0, 0, 0, 0, DEF,  0, 0, 0);
    tbl[2]  = mk("lu_rs1",          1, 5, 0, 5,  1, 0, 1, 0, 0, 0, LUS,  1, 0, 0);
    tbl[3]  = mk("lu_clear",        1, 5, 0, 5,  1, 0, 0, 0, 0, 0, DEF,  1, 0, 0);
    tbl[4]  = mk("lu_rd0",          1, 0, 0, 0,  1, 1, 1, 0, 0, 0, DEF,  1, 0, 0);
    tbl[5]  = mk("lu_nouse",        1, 7, 7, 7,  0, 0, 1, 0, 0, 0, DEF,  1, 0, 0);
    tbl[6]  = mk("lu_rs2",          1, 3, 9, 9,  1, 1, 1, 0, 0, 0, LUS,  2, 0, 0);
    tbl[7]  = mk("no_load",         1, 9, 9, 9,  1, 1, 0, 0, 0, 0, DEF,  2, 0, 0);
    tbl[8]  = mk("br_over_lu",      1, 5, 0, 5,  1, 0, 1, 1, 0, 0, BRF,  2, 1, 0);
    tbl[9]  = mk("done_in_run",     1, 0, 0, 0,  0, 0, 0, 0, 0, 1, DEF,  2, 1, 0);
    tbl[10] = mk("mdu_start",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, STA,  3, 1, 0);
    tbl[11] = mk("mdu_wait0",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ,  4, 1, 0);
    tbl[12] = mk("mdu_wait_ign",    1, 5, 0, 5,  1, 0, 1, 1, 1, 0, FRZ,  5, 1, 0);
    tbl[13] = mk("mdu_wait2",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ,  6, 1, 0);
    tbl[14] = mk("mdu_done",        1, 0, 0, 0,  0, 0, 0, 0, 1, 1, DEF,  6, 1, 0);
    tbl[15] = mk("after_mdu",       1, 0, 0, 0,  0, 0, 0, 0, 0, 0, DEF,  6, 1, 0);
    tbl[16] = mk("tmo_start",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, STA,  7, 1, 0);
    tbl[17] = mk("tmo_wait0",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ,  8, 1, 0);
    tbl[18] = mk("tmo_wait1",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ,  9, 1, 0);
    tbl[19] = mk("tmo_wait2",       1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ, 10, 1, 0);
    tbl[20] = mk("tmo_release",     1, 0, 0, 0,  0, 0, 0, 0, 1, 0, DEF, 10, 1, 1);
    tbl[21] = mk("tmo_run",         1, 0, 0, 0,  0, 0, 0, 0, 0, 0, DEF, 10, 1, 1);
    tbl[22] = mk("late_done",       1, 0, 0, 0,  0, 0, 0, 0, 0, 1, DEF, 10, 1, 1);
    tbl[23] = mk("rst_mdu_start",   1, 0, 0, 0,  0, 0, 0, 0, 1, 0, STA, 11, 1, 1);
    tbl[24] = mk("rst_mdu_wait",    1, 0, 0, 0,  0, 0, 0, 0, 1, 0, FRZ, 12, 1, 1);
    tbl[25] = mk("rst_mid_wait",    0, 0, 0, 0,  0, 0, 0, 0, 1, 0, DEF,  0, 0, 0);
    tbl[26] = mk("late_done_rst",   1, 0, 0, 0,  0, 0, 0, 0, 0, 1, DEF,  0, 0, 0);
    tbl[27] = mk("idle_after_rst",  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, DEF,  0, 0, 0);

    for (int i = 0; i < 28; i++) apply(tbl[i], 1'b0);

    // Back-to-back load-use then branch cycles drive both counters into saturation.
    apply(mk("sat_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0), 1'b0);
    for (int i = 0; i < 18; i++)
      apply(mk("sat_lu", 1, 5, 0, 5, 1, 0, 1, 0, 0, 0, LUS, (i + 1 > CMAX) ? CMAX : i + 1, 0, 0), 1'b0);
    for (int i = 0; i < 18; i++)
      apply(mk("sat_br", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRF, CMAX, (i + 1 > CMAX) ? CMAX : i + 1, 0), 1'b0);

    apply(mk("rand_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0), 1'b1);
    for (int i = 0; i < 800; i++) begin
      r = mk("rand", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0);
      r.rst = ($urandom_range(0, 59) != 0);
      r.rs1 = AW'($urandom_range(0, 3));
      r.rs2 = AW'($urandom_range(0, 3));
      r.rd  = AW'($urandom_range(0, 3));
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      r.mr  = 1'($urandom_range(0, 1));
      r.ms  = (m_wait >= 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
      r.br  = ($urandom_range(0, 5) == 0);
      if (m_wait < 0 && r.ms) r.br = 1'b0;
      r.md  = ($urandom_range(0, 3) == 0);
      apply(r, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
